// File: rtl/adc_scan_driver_pkg.sv
// Shared definitions for the MCP300x-class scanning ADC driver:
// FSM state encoding, protocol bit counts and the frame-length helper.
package adc_scan_driver_pkg;

    // One start bit and one null bit bracket the command/data fields.
    localparam int START_BIT = 1;
    localparam int NULL_BITS = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_MODE,
        S_CHAN,
        S_NULL,
        S_DATA,
        S_DONE,
        S_GAP
    } state_t;

    // Cycles with chip select low for one conversion frame:
    // start, SGL/DIFF, channel bits, null bit, data bits.
    function automatic int frame_len(input int data_w,
                                     input int ch_w);
        return START_BIT + 1 + ch_w + NULL_BITS + data_w;
    endfunction

endpackage

// File: rtl/adc_ch_sel.sv
// Next-enabled-channel finder for round-robin scanning.
// Ports:
//   mask    - channel enable mask, bit n enables channel n
//   ptr     - channel used by the previous scan frame
//   next_ch - first enabled channel strictly after ptr (wrapping)
//   wrap    - next_ch is the highest enabled channel
//   any_en  - at least one channel is enabled
module adc_ch_sel
    import adc_scan_driver_pkg::*;
#(
    parameter int CH_NUM = 8,
    parameter int CH_W   = 3
) (
    input  logic [CH_NUM-1:0] mask,
    input  logic [CH_W-1:0]   ptr,
    output logic [CH_W-1:0]   next_ch,
    output logic              wrap,
    output logic              any_en
);

    logic [CH_W-1:0] hi;
    logic [CH_W-1:0] bi;
    int              idx;

    always_comb begin
        next_ch = '0;
        hi      = '0;
        bi      = '0;
        idx     = 0;
        // Walk distances CH_NUM..1 so the nearest hit after ptr
        // is written last; distance CH_NUM is ptr itself, which
        // lets a single enabled channel repeat.
        for (int i = CH_NUM; i >= 1; i--) begin
            idx = (int'(ptr) + i) % CH_NUM;
            if (mask[idx[CH_W-1:0]]) begin
                next_ch = idx[CH_W-1:0];
            end
        end
        for (int i = 0; i < CH_NUM; i++) begin
            bi = CH_W'(i);
            if (mask[bi]) begin
                hi = bi;
            end
        end
    end

    assign any_en = |mask;
    assign wrap   = any_en && (next_ch == hi);

endmodule

// File: rtl/adc_scan_driver.sv
// SPI driver for MCP300x-class ADCs with single/scan channel modes.
// Ports:
//   s_clk_i        - serial clock; ADC SCLK is its inverse
//   rst_n_i        - asynchronous active-low reset
//   start_sample_i - level request, taken when a frame may start
//   scan_en_i      - 1: round-robin over ch_mask_i, 0: channel_num_i
//   channel_num_i  - channel used outside scan mode
//   ch_mask_i      - scan enable mask
//   single_ended_i - SGL/DIFF bit sent to the ADC
//   cs_o           - ADC chip select, active low
//   din_o          - command bit to the ADC
//   dout_i         - ADC serial data
//   data_ready_o   - one-cycle pulse, data_o/data_ch_o valid
//   data_o         - last conversion result
//   data_ch_o      - channel of data_o
//   busy_o         - frame in progress
//   scan_wrap_o    - result is from the highest enabled scan channel
module adc_scan_driver
    import adc_scan_driver_pkg::*;
#(
    parameter int DATA_W      = 10,
    parameter int CH_NUM      = 8,
    parameter int CH_W        = 3,
    parameter int CS_HIGH_CYC = 2
) (
    input  logic              s_clk_i,
    input  logic              rst_n_i,
    input  logic              start_sample_i,
    input  logic              scan_en_i,
    input  logic [CH_W-1:0]   channel_num_i,
    input  logic [CH_NUM-1:0] ch_mask_i,
    input  logic              single_ended_i,
    output logic              cs_o,
    output logic              din_o,
    input  logic              dout_i,
    output logic              data_ready_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CH_W-1:0]   data_ch_o,
    output logic              busy_o,
    output logic              scan_wrap_o
);

    localparam int FRAME_LEN = frame_len(DATA_W, CH_W);
    localparam int CNT_W     = $clog2(FRAME_LEN);
    localparam int GAP_W     = $clog2(CS_HIGH_CYC + 1);

    state_t            state;
    logic [CH_W-1:0]   ptr;
    logic [CH_W-1:0]   ch;
    logic [CH_W-1:0]   ch_sh;
    logic              sgl;
    logic              wrap_q;
    logic [CNT_W-1:0]  cnt;
    logic [GAP_W-1:0]  gap;
    logic [DATA_W-1:0] shift;

    logic [CH_W-1:0]   next_ch;
    logic              next_wrap;
    logic              any_en;
    logic              start_ok;
    logic              gap_ok;

    adc_ch_sel #(
        .CH_NUM (CH_NUM),
        .CH_W   (CH_W)
    ) u_ch_sel (
        .mask    (ch_mask_i),
        .ptr     (ptr),
        .next_ch (next_ch),
        .wrap    (next_wrap),
        .any_en  (any_en)
    );

    assign start_ok = start_sample_i && (!scan_en_i || any_en);

    // gap holds the high cycles still owed, counting the current
    // one; a frame may start at the edge ending the last of them.
    assign gap_ok = int'(gap) <= 1;

    always_ff @(posedge s_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state        <= S_IDLE;
            cs_o         <= 1'b1;
            din_o        <= 1'b0;
            data_ready_o <= 1'b0;
            data_o       <= '0;
            data_ch_o    <= '0;
            busy_o       <= 1'b0;
            scan_wrap_o  <= 1'b0;
            ptr          <= CH_W'(CH_NUM - 1);
            ch           <= '0;
            ch_sh        <= '0;
            sgl          <= 1'b0;
            wrap_q       <= 1'b0;
            cnt          <= '0;
            gap          <= '0;
            shift        <= '0;
        end else begin
            data_ready_o <= 1'b0;
            scan_wrap_o  <= 1'b0;
            if (cs_o && gap != '0) begin
                gap <= gap - 1'b1;
            end

            unique case (state)
                S_IDLE, S_DONE, S_GAP: begin
                    if (gap_ok && start_ok) begin
                        state  <= S_START;
                        cs_o   <= 1'b0;
                        din_o  <= 1'b1;
                        busy_o <= 1'b1;
                        sgl    <= single_ended_i;
                        if (scan_en_i) begin
                            ch     <= next_ch;
                            ptr    <= next_ch;
                            wrap_q <= next_wrap;
                        end else begin
                            ch     <= channel_num_i;
                            wrap_q <= 1'b0;
                        end
                    end else if (int'(gap) <= 2) begin
                        state <= S_IDLE;
                    end else begin
                        state <= S_GAP;
                    end
                end

                S_START: begin
                    state <= S_MODE;
                    din_o <= sgl;
                end

                S_MODE: begin
                    state <= S_CHAN;
                    din_o <= ch[CH_W-1];
                    ch_sh <= ch << 1;
                    cnt   <= CNT_W'(CH_W - 1);
                end

                S_CHAN: begin
                    if (cnt == '0) begin
                        state <= S_NULL;
                        din_o <= 1'b0;
                    end else begin
                        din_o <= ch_sh[CH_W-1];
                        ch_sh <= ch_sh << 1;
                        cnt   <= cnt - 1'b1;
                    end
                end

                S_NULL: begin
                    state <= S_DATA;
                    cnt   <= CNT_W'(DATA_W - 1);
                end

                S_DATA: begin
                    shift <= {shift[DATA_W-2:0], dout_i};
                    if (cnt == '0) begin
                        state        <= S_DONE;
                        cs_o         <= 1'b1;
                        din_o        <= 1'b0;
                        busy_o       <= 1'b0;
                        data_o       <= {shift[DATA_W-2:0], dout_i};
                        data_ch_o    <= ch;
                        data_ready_o <= 1'b1;
                        scan_wrap_o  <= wrap_q;
                        gap          <= GAP_W'(CS_HIGH_CYC);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_scan_driver.sv
// Scoreboard bench for adc_scan_driver: a default instance and a
// 12-bit/4-channel instance, each with a behavioural ADC model.
module tb_adc_scan_driver;

    typedef struct packed {
        logic [11:0] data;
        logic [2:0]  ch;
        logic        sgl;
        logic        wrap;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h",
                      tag, got, exp);
    endtask

    // default instance
    logic        start_a = 0, scan_en_a = 0, sgl_a = 0;
    logic [2:0]  ch_num_a = 0;
    logic [7:0]  mask_a = 0;
    logic        cs_a, din_a, rdy_a, busy_a, wrap_a;
    logic        dout_a = 0;
    logic [9:0]  data_a;
    logic [2:0]  dch_a;

    adc_scan_driver dut_a (
        .s_clk_i        (clk),
        .rst_n_i        (rst_n),
        .start_sample_i (start_a),
        .scan_en_i      (scan_en_a),
        .channel_num_i  (ch_num_a),
        .ch_mask_i      (mask_a),
        .single_ended_i (sgl_a),
        .cs_o           (cs_a),
        .din_o          (din_a),
        .dout_i         (dout_a),
        .data_ready_o   (rdy_a),
        .data_o         (data_a),
        .data_ch_o      (dch_a),
        .busy_o         (busy_a),
        .scan_wrap_o    (wrap_a)
    );

    // 12-bit, 4-channel, 3-cycle gap instance
    logic        start_b = 0, scan_en_b = 0, sgl_b = 0;
    logic [1:0]  ch_num_b = 0;
    logic [3:0]  mask_b = 0;
    logic        cs_b, din_b, rdy_b, busy_b, wrap_b;
    logic        dout_b = 0;
    logic [11:0] data_b;
    logic [1:0]  dch_b;

    adc_scan_driver #(
        .DATA_W      (12),
        .CH_NUM      (4),
        .CH_W        (2),
        .CS_HIGH_CYC (3)
    ) dut_b (
        .s_clk_i        (clk),
        .rst_n_i        (rst_n),
        .start_sample_i (start_b),
        .scan_en_i      (scan_en_b),
        .channel_num_i  (ch_num_b),
        .ch_mask_i      (mask_b),
        .single_ended_i (sgl_b),
        .cs_o           (cs_b),
        .din_o          (din_b),
        .dout_i         (dout_b),
        .data_ready_o   (rdy_b),
        .data_o         (data_b),
        .data_ch_o      (dch_b),
        .busy_o         (busy_b),
        .scan_wrap_o    (wrap_b)
    );

    exp_t cmd_q_a[$], res_q_a[$], cmd_q_b[$], res_q_b[$];
    exp_t cur_a, cur_b;
    int   pos_a = 0, pos_b = 0, hi_b = 0;
    int   rdy_cnt_a = 0, rdy_cnt_b = 0;
    bit   prev_rdy_a = 0, prev_rdy_b = 0, gap_on_b = 0;
    logic [5:0] cmd_a = 0;
    logic [4:0] cmd_b = 0;

    function automatic void push_a(input logic [2:0] c,
                                   input logic s,
                                   input logic [11:0] d,
                                   input logic w);
        exp_t e;
        e.ch = c; e.sgl = s; e.data = d; e.wrap = w;
        cmd_q_a.push_back(e);
        res_q_a.push_back(e);
    endfunction

    function automatic void push_b(input logic [2:0] c,
                                   input logic s,
                                   input logic [11:0] d);
        exp_t e;
        e.ch = c; e.sgl = s; e.data = d; e.wrap = 1'b0;
        cmd_q_b.push_back(e);
        res_q_b.push_back(e);
    endfunction

    // ADC model and result monitor, default instance
    always @(negedge clk) begin
        exp_t e;
        if (prev_rdy_a) chk("rdy_pulse_a", rdy_a, 1'b0);
        prev_rdy_a = rdy_a;
        if (rdy_a) begin
            rdy_cnt_a++;
            chk("cs_len_a", pos_a, 16);
            chk("cs_busy_done_a", {cs_a, busy_a}, 2'b10);
            if (res_q_a.size() == 0) begin
                chk("rdy_unexpected_a", res_q_a.size(), 1);
            end else begin
                e = res_q_a.pop_front();
                chk("data_a", data_a, e.data[9:0]);
                chk("data_ch_a", dch_a, e.ch);
                chk("scan_wrap_a", wrap_a, e.wrap);
            end
        end
        if (cs_a) begin
            pos_a  = 0;
            dout_a = 1'b0;
        end else begin
            cmd_a = {cmd_a[4:0], din_a};
            if (pos_a == 3) chk("busy_a", busy_a, 1'b1);
            if (pos_a == 5) begin
                if (cmd_q_a.size() == 0) begin
                    chk("frame_unexpected_a", cmd_q_a.size(), 1);
                    cur_a = '0;
                end else begin
                    cur_a = cmd_q_a.pop_front();
                    chk("cmd_a", cmd_a,
                        {1'b1, cur_a.sgl, cur_a.ch, 1'b0});
                end
            end
            if (pos_a >= 6 && pos_a < 16)
                dout_a = cur_a.data[15-pos_a];
            pos_a++;
        end
    end

    // ADC model and result monitor, 12-bit instance
    always @(negedge clk) begin
        exp_t e;
        if (prev_rdy_b) chk("rdy_pulse_b", rdy_b, 1'b0);
        prev_rdy_b = rdy_b;
        if (rdy_b) begin
            rdy_cnt_b++;
            chk("cs_len_b", pos_b, 17);
            if (res_q_b.size() == 0) begin
                chk("rdy_unexpected_b", res_q_b.size(), 1);
            end else begin
                e = res_q_b.pop_front();
                chk("data_b", data_b, e.data);
                chk("data_ch_b", dch_b, e.ch[1:0]);
                chk("scan_wrap_b", wrap_b, 1'b0);
            end
        end
        if (cs_b) begin
            pos_b  = 0;
            dout_b = 1'b0;
            hi_b++;
        end else begin
            if (pos_b == 0 && gap_on_b)
                chk("cs_gap_b", hi_b, 3);
            hi_b = 0;
            cmd_b = {cmd_b[3:0], din_b};
            if (pos_b == 4) begin
                if (cmd_q_b.size() == 0) begin
                    chk("frame_unexpected_b", cmd_q_b.size(), 1);
                    cur_b = '0;
                end else begin
                    cur_b = cmd_q_b.pop_front();
                    chk("cmd_b", cmd_b,
                        {1'b1, cur_b.sgl, cur_b.ch[1:0], 1'b0});
                end
            end
            if (pos_b >= 5 && pos_b < 17)
                dout_b = cur_b.data[16-pos_b];
            pos_b++;
        end
    end

    task automatic wait_rdy(input bit b);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(b ? rdy_b : rdy_a) && n < 100);
        if (!(b ? rdy_b : rdy_a))
            chk("rdy_timeout", b ? rdy_b : rdy_a, 1'b1);
    endtask

    task automatic wait_pos(input bit b, input int p);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while ((b ? pos_b : pos_a) != p && n < 100);
        if ((b ? pos_b : pos_a) != p)
            chk("pos_timeout", b ? pos_b : pos_a, p);
    endtask

    logic [2:0] scan_seq [5] = '{3'd0, 3'd2, 3'd7, 3'd0, 3'd2};
    int t_now, t_last, bad, cnt0;

    initial begin
        // reset values
        #1 rst_n = 1'b0;
        #1;
        chk("rst_cs_a", cs_a, 1'b1);
        chk("rst_ctl_a", {din_a, rdy_a, busy_a, wrap_a}, 4'h0);
        chk("rst_data_a", {data_a, dch_a}, 13'h0);
        chk("rst_cs_b", {cs_b, busy_b, rdy_b}, 3'b100);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // single channel 5, SGL
        @(negedge clk);
        scan_en_a = 0; ch_num_a = 3'd5; sgl_a = 1;
        push_a(3'd5, 1'b1, 12'h2C5, 1'b0);
        start_a = 1;
        @(negedge clk);
        start_a = 0; ch_num_a = 3'd2; sgl_a = 0;
        wait_rdy(0);
        repeat (5) @(negedge clk);
        chk("hold_data_a", data_a, 10'h2C5);
        chk("hold_ch_a", dch_a, 3'd5);

        // round-robin scan, start held
        scan_en_a = 1; mask_a = 8'b1000_0101; sgl_a = 1;
        for (int i = 0; i < 5; i++)
            push_a(scan_seq[i], 1'b1,
                   12'($urandom_range(0, 1023)),
                   scan_seq[i] == 3'd7);
        start_a = 1;
        for (int i = 0; i < 5; i++) begin
            wait_rdy(0);
            t_now = cyc;
            if (i > 0) chk("period_a", t_now - t_last, 18);
            t_last = t_now;
        end
        start_a = 0;

        // empty mask never starts a frame
        repeat (3) @(negedge clk);
        mask_a = 8'h00; start_a = 1; bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (!cs_a || busy_a || rdy_a) bad++;
        end
        chk("mask0_idle_a", bad, 0);
        push_a(3'd4, 1'b1, 12'h155, 1'b1);
        push_a(3'd4, 1'b1, 12'h2AA, 1'b1);
        mask_a = 8'h10;
        wait_rdy(0);
        wait_rdy(0);
        start_a = 0;

        // reset during the 4th data bit
        repeat (4) @(negedge clk);
        scan_en_a = 0; ch_num_a = 3'd3; sgl_a = 1;
        push_a(3'd3, 1'b1, 12'h3FF, 1'b0);
        start_a = 1;
        @(negedge clk);
        start_a = 0;
        cnt0 = rdy_cnt_a;
        wait_pos(0, 9);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_cs_a", {cs_a, busy_a, rdy_a}, 3'b100);
        void'(res_q_a.pop_back());
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_no_rdy_a", rdy_cnt_a, cnt0);
        // scan pointer restarts at the lowest enabled channel
        scan_en_a = 1; mask_a = 8'b1000_0101;
        push_a(3'd0, 1'b1, 12'h1A6, 1'b0);
        start_a = 1;
        @(negedge clk);
        start_a = 0;
        wait_rdy(0);

        // 12-bit instance: 3-cycle gap, SGL change mid-frame
        scan_en_b = 0; ch_num_b = 2'd3; sgl_b = 1; mask_b = 4'hF;
        push_b(3'd3, 1'b1, 12'hABC);
        push_b(3'd3, 1'b0, 12'($urandom_range(0, 4095)));
        push_b(3'd3, 1'b0, 12'($urandom_range(0, 4095)));
        start_b = 1;
        wait_pos(1, 3);
        sgl_b = 0;
        for (int i = 0; i < 3; i++) begin
            wait_rdy(1);
            gap_on_b = 1;
            t_now = cyc;
            if (i > 0) chk("period_b", t_now - t_last, 20);
            t_last = t_now;
        end
        start_b = 0;
        gap_on_b = 0;

        repeat (30) @(negedge clk);
        chk("res_left_a", res_q_a.size(), 0);
        chk("res_left_b", res_q_b.size(), 0);
        chk("rdy_total_b", rdy_cnt_b, 3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
